axi_ram: RTL and testbench
==========================

Name: axi_ram

Overview:
AXI4 slave memory (no ID signals) with a 64-bit data bus and a 32-bit address. It sits on an AXI interconnect port as on-chip RAM. It has independent write (AW/W/B) and read (AR/R) engines, each handling one burst at a time. It supports FIXED, INCR and WRAP bursts with byte strobes.

Parameters:
DATA_WIDTH, 64, data bus width in bits; the byte-lane count is DATA_WIDTH/8.
ADDR_WIDTH, 32, byte address width.
MEM_WORDS, 256, depth in DATA_WIDTH words (2 KiB); the word index is addr[3 +: log2(MEM_WORDS)].

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_awready out 1 / s_awvalid in 1 / s_awburst in 2 / s_awsize in 3 / s_awlen in 8 / s_awaddr in 32  write address channel
s_wready out 1 / s_wvalid in 1 / s_wlast in 1 / s_wdata in 64 / s_wstrb in 8  write data channel
s_bvalid out 1 / s_bready in 1 / s_bresp out 2  write response channel
s_arready out 1 / s_arvalid in 1 / s_arburst in 2 / s_arsize in 3 / s_arlen in 8 / s_araddr in 32  read address channel
s_rvalid out 1 / s_rready in 1 / s_rlast out 1 / s_rdata out 64 / s_rresp out 2  read data channel

Behaviour:
- Reset (async, rst_n=0): both FSMs go to IDLE. While rst_n is low, all outputs are 0. Memory contents are not reset. Reset mid-burst abandons the burst with no B/R response.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: s_awready=1, s_wready=1. On an AW handshake, latch addr/len/size/burst and set beat count 0.
  - A W beat presented in the same cycle as the AW handshake is accepted and written at awaddr (count becomes 1). W beats in W_IDLE without AW are not accepted.
  - W_DATA: s_wready=1, s_awready=0. Each W handshake writes the bytes whose strobe bit is set, then advances the address.
  - The burst ends on the beat where count==awlen; then go to W_RESP.
  - W_RESP: s_bvalid=1 until s_bready; then return to W_IDLE.
  - bresp is OKAY (00). It is SLVERR (10) if s_wlast was not high on exactly the final beat. An early wlast does not end the burst.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: s_arready=1. On an AR handshake, latch fields and go to R_DATA next cycle.
  - R_DATA: s_rvalid=1; s_rdata = mem[current word] (combinational read of current array state); s_rlast=1 when count==arlen; s_rresp=OKAY.
  - Address and count advance only on an R handshake. rdata/rlast are held while s_rready=0.
  - After the last handshake, return to R_IDLE with s_arready=1 the following cycle.
- Address update, step=1<<size:
  - FIXED(0): address is unchanged.
  - INCR(1): addr+step.
  - WRAP(2): wrap within an aligned block of (len+1)*step bytes; len must be 1, 3, 7 or 15, otherwise treat as INCR.
  - Burst type 3: treat as INCR.
  - size>3: treat as 3.
- Narrow transfers: strobes are authoritative; the word index is always taken from the aligned address.
- Addresses beyond MEM_WORDS alias modulo the depth and respond OKAY.
- Read and write engines run concurrently and independently. If both touch the same word in the same cycle, the read returns the old data; the write is visible from the next cycle.
- Every write beat, read beat, response and state change happens on a single rising edge, with no extra latency beyond what is stated.

Decomposition:
- Package axi_ram_pkg: burst-type constants (FIXED/INCR/WRAP), response codes (OKAY=00, SLVERR=10), and FSM state typedefs.
- One sub-module, axi_burst_addr: pure combinational next-address computation (addr, size, len, burst) -> next addr. It is instantiated once for write and once for read.

Test Plan:
- Write INCR: AW addr 0, len 7, size 3, with W data 5..12 (full strobes) back-to-back starting in the AW cycle, wlast on beat 8 -> bvalid next cycle, bresp=00.
- Read INCR: AR addr 0, len 7, rready=1 -> rdata 5,6,...,12 on consecutive cycles, rlast only with 12, rresp=00.
- Concurrent: read of addr 0 while writing 13..20 at addr 64 -> read returns 5..12. Then AR at 64 -> 13..20.
- Strobe/backpressure:
  - Write 0xFFFF_FFFF_FFFF_FFFF to 0, then 0 with wstrb=0x0F -> read 0xFFFF_FFFF_0000_0000.
  - Toggling rready holds rdata stable.
- WRAP: AW addr 0x10, len 3, size 3, data A,B,C,D -> words 0x10,0x18,0x00,0x08. INCR read from 0 returns C,D,A,B.
- Errors/reset:
  - wlast missing on final beat -> bresp=10.
  - rst_n pulsed low mid-read burst -> rvalid=0 immediately; arready=1 after release.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM state types for the axi_ram slave memory.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_ram_if.sv
// AXI4 (no ID) slave-side bundle for axi_ram: AW/W/B write and AR/R read channels.
interface axi_ram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                    s_awready;
  logic                    s_awvalid;
  logic [1:0]              s_awburst;
  logic [2:0]              s_awsize;
  logic [7:0]              s_awlen;
  logic [ADDR_WIDTH-1:0]   s_awaddr;

  logic                    s_wready;
  logic                    s_wvalid;
  logic                    s_wlast;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;

  logic                    s_bvalid;
  logic                    s_bready;
  logic [1:0]              s_bresp;

  logic                    s_arready;
  logic                    s_arvalid;
  logic [1:0]              s_arburst;
  logic [2:0]              s_arsize;
  logic [7:0]              s_arlen;
  logic [ADDR_WIDTH-1:0]   s_araddr;

  logic                    s_rvalid;
  logic                    s_rready;
  logic                    s_rlast;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;

  modport slave (
    output s_awready, input s_awvalid, input s_awburst, input s_awsize, input s_awlen, input s_awaddr,
    output s_wready, input s_wvalid, input s_wlast, input s_wdata, input s_wstrb,
    output s_bvalid, input s_bready, output s_bresp,
    output s_arready, input s_arvalid, input s_arburst, input s_arsize, input s_arlen, input s_araddr,
    output s_rvalid, input s_rready, output s_rlast, output s_rdata, output s_rresp
  );

  modport master (
    input s_awready, output s_awvalid, output s_awburst, output s_awsize, output s_awlen, output s_awaddr,
    input s_wready, output s_wvalid, output s_wlast, output s_wdata, output s_wstrb,
    input s_bvalid, output s_bready, input s_bresp,
    input s_arready, output s_arvalid, output s_arburst, output s_arsize, output s_arlen, output s_araddr,
    input s_rvalid, output s_rready, input s_rlast, input s_rdata, input s_rresp
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for AXI FIXED / INCR / WRAP bursts.
module axi_burst_addr
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_SIZE   = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [2:0]            size_eff;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  // Sizes wider than the bus are clamped to the bus width.
  assign size_eff  = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
  assign step      = ADDR_WIDTH'(1) << size_eff;
  assign incr_addr = addr + step;
  // Only 2/4/8/16-beat wraps are legal; anything else degrades to INCR.
  assign wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size_eff) - ADDR_WIDTH'(1);

  // Select the next address by burst type; reserved type 3 behaves as INCR.
  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_ram.sv
// AXI4 slave on-chip RAM with independent single-burst write and read engines.
module axi_ram
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  axi_ram_if.slave  s
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Write engine state
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, w_we;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_cur_addr, w_next_addr;
  logic [7:0]            w_cur_len;
  logic [2:0]            w_cur_size;
  logic [1:0]            w_cur_burst;
  logic                  w_last_beat, w_err_now;
  logic [IDX_W-1:0]      w_idx;

  // Read engine state
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;

  logic                  ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [IDX_W-1:0]      r_idx;

  // Ready flops reset to 1 so the engines accept right after release;
  // masking with rst_n keeps every output low while reset is held.
  assign s.s_awready = awready_q & rst_n;
  assign s.s_wready  = wready_q & rst_n;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = arready_q & rst_n;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rlast   = rlast_q;
  assign s.s_rresp   = RESP_OKAY;
  assign s.s_rdata   = rvalid_q ? mem[r_idx] : '0;

  assign aw_hs  = s.s_awvalid & awready_q & rst_n;
  assign w_hs   = s.s_wvalid & wready_q & rst_n;
  assign ar_hs  = s.s_arvalid & arready_q & rst_n;
  assign r_hs   = s.s_rready & rvalid_q;
  assign w_idle = (w_state_q == W_IDLE);

  // In W_IDLE a beat riding with AW uses the AW fields directly.
  assign w_cur_addr  = w_idle ? s.s_awaddr  : waddr_q;
  assign w_cur_len   = w_idle ? s.s_awlen   : wlen_q;
  assign w_cur_size  = w_idle ? s.s_awsize  : wsize_q;
  assign w_cur_burst = w_idle ? s.s_awburst : wburst_q;
  assign w_last_beat = w_idle ? (s.s_awlen == 8'd0) : (wcnt_q == wlen_q);
  // Error is sticky across the burst: wlast must match the final beat exactly.
  assign w_err_now   = (w_idle ? 1'b0 : werr_q) | (s.s_wlast != w_last_beat);
  assign w_idx       = w_cur_addr[BYTE_SHIFT +: IDX_W];
  assign r_idx       = raddr_q[BYTE_SHIFT +: IDX_W];

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(BYTE_SHIFT)) u_waddr (
    .addr      (w_cur_addr),
    .size      (w_cur_size),
    .len       (w_cur_len),
    .burst     (w_cur_burst),
    .next_addr (w_next_addr)
  );

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(BYTE_SHIFT)) u_raddr (
    .addr      (raddr_q),
    .size      (rsize_q),
    .len       (rlen_q),
    .burst     (rburst_q),
    .next_addr (r_next_addr)
  );

  // Write engine next-state: accept AW (+ optional first beat), stream beats, then B.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          waddr_d   = s.s_awaddr;
          wlen_d    = s.s_awlen;
          wsize_d   = s.s_awsize;
          wburst_d  = s.s_awburst;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          if (w_hs) begin
            w_we    = 1'b1;
            waddr_d = w_next_addr;
            wcnt_d  = 8'd1;
            werr_d  = w_err_now;
            if (w_last_beat) begin
              w_state_d = W_RESP;
              wready_d  = 1'b0;
              bvalid_d  = 1'b1;
              bresp_d   = w_err_now ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_we    = 1'b1;
          waddr_d = w_next_addr;
          wcnt_d  = wcnt_q + 8'd1;
          werr_d  = w_err_now;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_now ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s.s_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Write FSM and its registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Latched write-burst fields; only meaningful while a burst is open.
  always_ff @(posedge clk) begin
    waddr_q  <= waddr_d;
    wlen_q   <= wlen_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
  end

  // Byte-lane writes; the read port sees the new word from the next cycle.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s.s_wstrb[i]) mem[w_idx][8*i +: 8] <= s.s_wdata[8*i +: 8];
      end
    end
  end

  // Read engine next-state: accept AR, then present beats advancing on R handshakes.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d   = s.s_araddr;
          rlen_d    = s.s_arlen;
          rsize_d   = s.s_arsize;
          rburst_d  = s.s_arburst;
          rcnt_d    = 8'd0;
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (s.s_arlen == 8'd0);
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            raddr_d = r_next_addr;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Read FSM and its registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= 8'd0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Latched read-burst fields; only meaningful while a burst is open.
  always_ff @(posedge clk) begin
    raddr_q  <= raddr_d;
    rlen_q   <= rlen_d;
    rsize_q  <= rsize_d;
    rburst_q <= rburst_d;
  end

endmodule

// File: tb/tb_axi_ram.sv
// Directed self-checking bench for axi_ram: bursts, strobes, backpressure, errors, reset.
module tb_axi_ram;

  typedef logic [63:0] beats_t [16];

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  axi_ram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

  axi_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wl_mode: 0 = wlast on final beat, 1 = never, 2 = on first beat only
  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input beats_t d,
                           input logic [7:0] strb, input int wl_mode, input logic [1:0] exp_resp);
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = addr;
    bus.s_awlen   = len;
    bus.s_awsize  = size;
    bus.s_awburst = burst;
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_wvalid = 1'b1;
      bus.s_wdata  = d[i];
      bus.s_wstrb  = strb;
      case (wl_mode)
        0:       bus.s_wlast = (i == int'(len));
        1:       bus.s_wlast = 1'b0;
        default: bus.s_wlast = (i == 0);
      endcase
      if (i == 0) begin
        chk($sformatf("%s.awready", tag), bus.s_awready, 64'd1);
      end else begin
        bus.s_awvalid = 1'b0;
        chk($sformatf("%s.awready_busy[%0d]", tag, i), bus.s_awready, 64'd0);
        chk($sformatf("%s.bvalid_early[%0d]", tag, i), bus.s_bvalid, 64'd0);
      end
      chk($sformatf("%s.wready[%0d]", tag, i), bus.s_wready, 64'd1);
      tick();
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_wlast   = 1'b0;
    chk($sformatf("%s.bvalid", tag), bus.s_bvalid, 64'd1);
    chk($sformatf("%s.bresp", tag), bus.s_bresp, 64'(exp_resp));
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    chk($sformatf("%s.bvalid_clr", tag), bus.s_bvalid, 64'd0);
    chk($sformatf("%s.awready_back", tag), bus.s_awready, 64'd1);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input beats_t e);
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = addr;
    bus.s_arlen   = len;
    bus.s_arsize  = size;
    bus.s_arburst = burst;
    chk($sformatf("%s.arready", tag), bus.s_arready, 64'd1);
    tick();
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk($sformatf("%s.rvalid[%0d]", tag, i), bus.s_rvalid, 64'd1);
      chk($sformatf("%s.rdata[%0d]", tag, i), bus.s_rdata, e[i]);
      chk($sformatf("%s.rlast[%0d]", tag, i), bus.s_rlast, (i == int'(len)) ? 64'd1 : 64'd0);
      if (i == 0) chk($sformatf("%s.rresp", tag), bus.s_rresp, 64'd0);
      tick();
    end
    bus.s_rready = 1'b0;
    chk($sformatf("%s.rvalid_clr", tag), bus.s_rvalid, 64'd0);
    chk($sformatf("%s.arready_back", tag), bus.s_arready, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beats_t d, e, dw, er;
    int     k;
    logic [63:0] va, vb, vc, vd;
    va = 64'h1111_2222_3333_4444;
    vb = 64'h5555_6666_7777_8888;
    vc = 64'h9999_AAAA_BBBB_CCCC;
    vd = 64'hDDDD_EEEE_0123_4567;
    d = '{default: 64'd0};
    e = '{default: 64'd0};
    dw = '{default: 64'd0};
    er = '{default: 64'd0};

    rst_n = 1'b0;
    bus.s_awvalid = 1'b0; bus.s_awburst = 2'd0; bus.s_awsize = 3'd0; bus.s_awlen = 8'd0; bus.s_awaddr = 32'd0;
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.s_wdata = 64'd0; bus.s_wstrb = 8'd0;
    bus.s_bready = 1'b0;
    bus.s_arvalid = 1'b0; bus.s_arburst = 2'd0; bus.s_arsize = 3'd0; bus.s_arlen = 8'd0; bus.s_araddr = 32'd0;
    bus.s_rready = 1'b0;
    #1;
    chk("rst.awready", bus.s_awready, 64'd0);
    chk("rst.wready", bus.s_wready, 64'd0);
    chk("rst.arready", bus.s_arready, 64'd0);
    chk("rst.bvalid", bus.s_bvalid, 64'd0);
    chk("rst.rvalid", bus.s_rvalid, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rel.awready", bus.s_awready, 64'd1);
    chk("rel.wready", bus.s_wready, 64'd1);
    chk("rel.arready", bus.s_arready, 64'd1);
    tick();

    // INCR write 5..12 at 0, then read back
    for (int i = 0; i < 8; i++) d[i] = 64'(i + 5);
    axi_write("wincr", 32'h0, 8'd7, 3'd3, 2'd1, d, 8'hFF, 0, 2'b00);
    axi_read("rincr", 32'h0, 8'd7, 3'd3, 2'd1, d);

    // Concurrent: write 13..20 at 64 while reading 0
    for (int i = 0; i < 8; i++) dw[i] = 64'(i + 13);
    for (int i = 0; i < 8; i++) er[i] = 64'(i + 5);
    fork
      axi_write("cw", 32'd64, 8'd7, 3'd3, 2'd1, dw, 8'hFF, 0, 2'b00);
      axi_read("cr", 32'd0, 8'd7, 3'd3, 2'd1, er);
    join
    tick();
    axi_read("r64", 32'd64, 8'd7, 3'd3, 2'd1, dw);

    // Strobes: all-ones then zero low half
    d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write("sfull", 32'h0, 8'd0, 3'd3, 2'd1, d, 8'hFF, 0, 2'b00);
    d[0] = 64'h0;
    axi_write("slow", 32'h0, 8'd0, 3'd3, 2'd1, d, 8'h0F, 0, 2'b00);
    e[0] = 64'hFFFF_FFFF_0000_0000;
    axi_read("sread", 32'h0, 8'd0, 3'd3, 2'd1, e);

    // Backpressure: rready toggles, data must hold while low
    e[0] = 64'hFFFF_FFFF_0000_0000; e[1] = 64'd6; e[2] = 64'd7; e[3] = 64'd8;
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h0; bus.s_arlen = 8'd3; bus.s_arsize = 3'd3; bus.s_arburst = 2'd1;
    tick();
    bus.s_arvalid = 1'b0;
    k = 0;
    for (int c = 0; c < 16 && k <= 3; c++) begin
      bus.s_rready = c[0];
      chk($sformatf("bp.rdata[c%0d]", c), bus.s_rdata, e[k]);
      chk($sformatf("bp.rlast[c%0d]", c), bus.s_rlast, (k == 3) ? 64'd1 : 64'd0);
      tick();
      if (c[0]) k++;
    end
    bus.s_rready = 1'b0;
    chk("bp.rvalid_clr", bus.s_rvalid, 64'd0);

    // WRAP write at 0x10: A,B -> words 2,3; C,D wrap to words 0,1
    d[0] = va; d[1] = vb; d[2] = vc; d[3] = vd;
    axi_write("wwrap", 32'h10, 8'd3, 3'd3, 2'd2, d, 8'hFF, 0, 2'b00);
    e[0] = vc; e[1] = vd; e[2] = va; e[3] = vb;
    axi_read("rafterwrap", 32'h0, 8'd3, 3'd3, 2'd1, e);
    axi_read("rwrap", 32'h10, 8'd3, 3'd3, 2'd2, d);

    // FIXED write leaves last beat in word 4
    d[0] = 64'd1; d[1] = 64'd2; d[2] = 64'd3;
    axi_write("wfixed", 32'h20, 8'd2, 3'd3, 2'd0, d, 8'hFF, 0, 2'b00);
    e[0] = 64'd3; e[1] = 64'd3;
    axi_read("rfixed", 32'h20, 8'd1, 3'd3, 2'd0, e);

    // Address 0x808 aliases word 1
    d[0] = 64'h55;
    axi_write("walias", 32'h808, 8'd0, 3'd3, 2'd1, d, 8'hFF, 0, 2'b00);
    e[0] = 64'h55;
    axi_read("ralias", 32'h8, 8'd0, 3'd3, 2'd1, e);

    // wlast errors
    d[0] = 64'd7; d[1] = 64'd8;
    axi_write("nolast", 32'h80, 8'd1, 3'd3, 2'd1, d, 8'hFF, 1, 2'b10);
    axi_write("early", 32'h80, 8'd1, 3'd3, 2'd1, d, 8'hFF, 2, 2'b10);

    // Reset in the middle of a read burst
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h0; bus.s_arlen = 8'd7; bus.s_arsize = 3'd3; bus.s_arburst = 2'd1;
    tick();
    bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.rvalid", bus.s_rvalid, 64'd0);
    chk("mrst.rdata", bus.s_rdata, 64'd0);
    chk("mrst.arready", bus.s_arready, 64'd0);
    chk("mrst.awready", bus.s_awready, 64'd0);
    bus.s_rready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("mrel.arready", bus.s_arready, 64'd1);
    chk("mrel.rvalid", bus.s_rvalid, 64'd0);
    tick();
    e[0] = vc;
    axi_read("rpostrst", 32'h0, 8'd0, 3'd3, 2'd1, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
